// File: rtl/irq_priority_controller.sv
// Captures rising edges on four request lines into a pending register and
// hands out the highest-priority unmasked pending line over valid/ready.
module irq_priority_controller #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req_in,
   input  logic [NUM_REQ-1:0] mask,
   input  logic               irq_ready,
   output logic               irq_valid,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_REQ-1:0] pending,
   output logic               overrun
);

   typedef enum logic {
      IDLE,
      PRESENT
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [NUM_REQ-1:0] req_q;
   logic [NUM_REQ-1:0] edge_v;
   logic [NUM_REQ-1:0] clear_v;
   logic [NUM_REQ-1:0] pending_next;
   logic [NUM_REQ-1:0] eligible;
   logic               overrun_next;
   logic               valid_next;
   logic [ID_W-1:0]    id_next;

   // A fresh edge on a bit being acknowledged wins, so the set is OR-ed in last.
   always_comb begin
      edge_v  = req_in & ~req_q;
      clear_v = '0;
      if (irq_valid && irq_ready) begin
         clear_v[irq_id] = 1'b1;
      end
      pending_next = (pending & ~clear_v) | edge_v;
      overrun_next = |(edge_v & pending & ~clear_v);
   end

   always_comb begin
      state_next = state;
      valid_next = irq_valid;
      id_next    = irq_id;
      eligible   = pending & ~mask;
      case (state)
         IDLE: begin
            valid_next = 1'b0;
            if (|eligible) begin
               // Ascending scan: the highest set index is assigned last and wins.
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (eligible[i]) begin
                     id_next = ID_W'(i);
                  end
               end
               valid_next = 1'b1;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (irq_ready) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_q     <= '0;
         pending   <= '0;
         irq_valid <= 1'b0;
         irq_id    <= '0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_next;
         req_q     <= req_in;
         pending   <= pending_next;
         irq_valid <= valid_next;
         irq_id    <= id_next;
         overrun   <= overrun_next;
      end
   end

endmodule

// File: tb/tb_irq_priority_controller.sv
// Directed bench for irq_priority_controller: a per-line event model is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_irq_priority_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_in;
   logic [3:0] mask;
   logic       irq_ready;
   logic       irq_valid;
   logic [1:0] irq_id;
   logic [3:0] pending;
   logic       overrun;

   int n_compared   = 0;
   int n_mismatched = 0;

   irq_priority_controller #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .mask      (mask),
      .irq_ready (irq_ready),
      .irq_valid (irq_valid),
      .irq_id    (irq_id),
      .pending   (pending),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Reference model: one flag per line, a "presenting" flag and the held ID.
   bit m_req_q [4];
   bit m_pend  [4];
   bit m_next  [4];
   bit m_valid;
   int m_id;
   bit m_ovr;
   bit m_ovr_next;
   bit m_ev;
   int clr_idx;
   int best;
   bit model_live = 1'b0;

   function automatic logic [3:0] pack4(input bit a [4]);
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = a[i];
      return v;
   endfunction

   always @(posedge clk) begin
      model_live = 1'b1;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_req_q[i] = 1'b0;
            m_pend[i]  = 1'b0;
         end
         m_valid = 1'b0;
         m_id    = 0;
         m_ovr   = 1'b0;
      end else begin
         clr_idx    = (m_valid && irq_ready) ? m_id : -1;
         m_ovr_next = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_ev = req_in[i] && !m_req_q[i];
            if (m_ev && m_pend[i] && i != clr_idx) m_ovr_next = 1'b1;
            if (m_ev) m_next[i] = 1'b1;
            else if (i == clr_idx) m_next[i] = 1'b0;
            else m_next[i] = m_pend[i];
         end
         if (m_valid) begin
            if (irq_ready) m_valid = 1'b0;
         end else begin
            best = -1;
            for (int i = 0; i < 4; i++)
               if (m_pend[i] && !mask[i]) best = i;
            if (best >= 0) begin
               m_valid = 1'b1;
               m_id    = best;
            end
         end
         for (int i = 0; i < 4; i++) begin
            m_req_q[i] = req_in[i];
            m_pend[i]  = m_next[i];
         end
         m_ovr = m_ovr_next;
      end
   end

   task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_live) begin
         checkOutput("model_valid",   {3'b0, irq_valid}, {3'b0, m_valid});
         checkOutput("model_id",      {2'b0, irq_id},    4'(m_id));
         checkOutput("model_pending", pending,           pack4(m_pend));
         checkOutput("model_overrun", {3'b0, overrun},   {3'b0, m_ovr});
      end
   end

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] m, input logic rd);
      req_in    = r;
      mask      = m;
      irq_ready = rd;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;
      checkOutput("reset_pending", pending, 4'b0000);
      checkOutput("reset_valid", {3'b0, irq_valid}, 4'b0000);
      checkOutput("reset_overrun", {3'b0, overrun}, 4'b0000);

      // Single event on line 2, then level-held without a new event.
      applyStimulus(4'b0100, 4'b0000, 1'b0);
      checkOutput("single_pend", pending, 4'b0100);
      checkOutput("single_novalid", {3'b0, irq_valid}, 4'b0000);
      applyStimulus(4'b0100, 4'b0000, 1'b0);
      checkOutput("single_valid", {3'b0, irq_valid}, 4'b0001);
      checkOutput("single_id", {2'b0, irq_id}, 4'b0010);
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      checkOutput("single_ack_pend", pending, 4'b0000);
      checkOutput("single_ack_valid", {3'b0, irq_valid}, 4'b0000);
      applyStimulus(4'b0100, 4'b0000, 1'b0);
      applyStimulus(4'b0100, 4'b0000, 1'b0);
      checkOutput("held_no_event", {3'b0, irq_valid}, 4'b0000);
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      // Priority order 3, 1, 0 with ready held high.
      applyStimulus(4'b1011, 4'b0000, 1'b1);
      checkOutput("prio_pend", pending, 4'b1011);
      applyStimulus(4'b1011, 4'b0000, 1'b1);
      checkOutput("prio_id3", {2'b0, irq_id}, 4'b0011);
      applyStimulus(4'b1011, 4'b0000, 1'b1);
      checkOutput("prio_bubble", {3'b0, irq_valid}, 4'b0000);
      applyStimulus(4'b1011, 4'b0000, 1'b1);
      checkOutput("prio_id1", {2'b0, irq_id}, 4'b0001);
      applyStimulus(4'b1011, 4'b0000, 1'b1);
      applyStimulus(4'b1011, 4'b0000, 1'b1);
      checkOutput("prio_id0", {2'b0, irq_id}, 4'b0000);
      checkOutput("prio_id0_valid", {3'b0, irq_valid}, 4'b0001);
      applyStimulus(4'b1011, 4'b0000, 1'b1);
      checkOutput("prio_end_pend", pending, 4'b0000);
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      // Presented ID held while a higher-priority line arrives.
      applyStimulus(4'b0010, 4'b0000, 1'b0);
      applyStimulus(4'b0010, 4'b0000, 1'b0);
      applyStimulus(4'b1010, 4'b0000, 1'b0);
      applyStimulus(4'b1010, 4'b0000, 1'b0);
      checkOutput("hold_id1", {2'b0, irq_id}, 4'b0001);
      checkOutput("hold_pend", pending, 4'b1010);
      applyStimulus(4'b1010, 4'b0000, 1'b1);
      applyStimulus(4'b1010, 4'b0000, 1'b0);
      checkOutput("hold_then_id3", {2'b0, irq_id}, 4'b0011);
      applyStimulus(4'b1010, 4'b0000, 1'b1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      // Masked line stays pending until unmasked.
      applyStimulus(4'b1000, 4'b1000, 1'b0);
      applyStimulus(4'b1000, 4'b1000, 1'b0);
      applyStimulus(4'b1000, 4'b1000, 1'b0);
      checkOutput("mask_blocked", {3'b0, irq_valid}, 4'b0000);
      checkOutput("mask_pend", pending, 4'b1000);
      applyStimulus(4'b1000, 4'b0000, 1'b0);
      checkOutput("unmask_valid", {3'b0, irq_valid}, 4'b0001);
      checkOutput("unmask_id", {2'b0, irq_id}, 4'b0011);
      applyStimulus(4'b1000, 4'b0000, 1'b1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      // Second edge on a pending line merges and pulses overrun once.
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("overrun_pulse", {3'b0, overrun}, 4'b0001);
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("overrun_once", {3'b0, overrun}, 4'b0000);
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("merged_single", {3'b0, irq_valid}, 4'b0000);

      // Edge in the same cycle as its own handshake keeps the bit pending.
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      checkOutput("collide_pend", pending, 4'b0001);
      checkOutput("collide_no_ovr", {3'b0, overrun}, 4'b0000);
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("collide_again", {3'b0, irq_valid}, 4'b0001);
      checkOutput("collide_id", {2'b0, irq_id}, 4'b0000);
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      // Reset while presenting, overriding a simultaneous handshake.
      applyStimulus(4'b1110, 4'b0000, 1'b0);
      applyStimulus(4'b1110, 4'b0000, 1'b0);
      rst = 1'b1;
      applyStimulus(4'b1110, 4'b0000, 1'b1);
      rst = 1'b0;
      checkOutput("rst_mid_valid", {3'b0, irq_valid}, 4'b0000);
      checkOutput("rst_mid_pend", pending, 4'b0000);
      checkOutput("rst_mid_ovr", {3'b0, overrun}, 4'b0000);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
